// File: rtl/load_store_unit.sv
// RV32I load/store sequencer for a word-addressed, byte-masked data memory.
// Each op becomes one memory transaction; the core is stalled until the handshake completes or times out.
module load_store_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  store_en,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           store_data,
  output logic                  stall,
  output logic                  done,
  output logic [31:0]           load_result,
  output logic                  misaligned,
  output logic                  fault,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_w_data,
  output logic [3:0]            mem_masking,
  output logic                  mem_we_re,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_r_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic                  r_is_store;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;
  logic [7:0]            r_cnt;
  logic                  r_done;
  logic                  r_fault;
  logic                  r_misaligned;
  logic [31:0]           r_load_result;
  logic                  r_mem_request;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_w_data;
  logic [3:0]            r_mem_masking;
  logic                  r_mem_we_re;

  logic                  w_accept;
  logic                  w_is_store;
  logic                  w_legal;
  logic                  w_align_err;
  logic                  w_go;
  logic [3:0]            w_mask;
  logic [31:0]           w_wdata;
  logic [7:0]            w_rd_byte [4];
  logic [7:0]            w_sel_byte;
  logic [15:0]           w_sel_half;
  logic [31:0]           w_extracted;
  logic                  w_unused;

  // Upper address bits wrap away in the word-addressed memory.
  assign w_unused = ^{addr[31:ADDR_WIDTH+2]};

  // ---------------------------------------------------------------- decode
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && (load_en || store_en);
  assign w_is_store = store_en;

  always_comb begin
    w_legal = 1'b0;
    if (w_is_store) begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end
  end

  always_comb begin
    w_align_err = 1'b0;
    case (funct3[1:0])
      2'b01:   w_align_err = addr[0];
      2'b10:   w_align_err = (addr[1:0] != 2'b00);
      default: w_align_err = 1'b0;
    endcase
  end

  assign w_go  = w_accept && w_legal && !w_align_err;
  assign stall = (r_state == S_ISSUE) || (r_state == S_WAIT) || w_go;

  // ------------------------------------------------------ store lane setup
  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = '0;
    if (w_is_store) begin
      case (funct3[1:0])
        2'b00: begin
          w_mask  = 4'b0001 << addr[1:0];
          w_wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          w_mask  = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{store_data[15:0]}};
        end
        default: begin
          w_mask  = 4'b1111;
          w_wdata = store_data;
        end
      endcase
    end
  end

  // ------------------------------------------------------- load extraction
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign w_rd_byte[gi] = mem_r_data[8*gi +: 8];
    end
  endgenerate

  assign w_sel_byte = w_rd_byte[r_lane];
  assign w_sel_half = r_lane[1] ? mem_r_data[31:16] : mem_r_data[15:0];

  always_comb begin
    w_extracted = '0;
    if (!r_is_store) begin
      case (r_funct3)
        3'b000:  w_extracted = {{24{w_sel_byte[7]}}, w_sel_byte};
        3'b001:  w_extracted = {{16{w_sel_half[15]}}, w_sel_half};
        3'b010:  w_extracted = mem_r_data;
        3'b100:  w_extracted = {24'd0, w_sel_byte};
        3'b101:  w_extracted = {16'd0, w_sel_half};
        default: w_extracted = '0;
      endcase
    end
  end

  // -------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_is_store    <= 1'b0;
      r_funct3      <= '0;
      r_lane        <= '0;
      r_cnt         <= '0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_misaligned  <= 1'b0;
      r_load_result <= '0;
      r_mem_request <= 1'b0;
      r_mem_address <= '0;
      r_mem_w_data  <= '0;
      r_mem_masking <= '0;
      r_mem_we_re   <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_misaligned  <= 1'b0;
      r_mem_request <= 1'b0;
      r_load_result <= '0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (w_accept) begin
            if (!w_legal) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
            end else if (w_align_err) begin
              r_misaligned <= 1'b1;
            end else begin
              r_state       <= S_ISSUE;
              r_is_store    <= w_is_store;
              r_funct3      <= funct3;
              r_lane        <= addr[1:0];
              r_mem_request <= 1'b1;
              r_mem_address <= addr[ADDR_WIDTH+1:2];
              r_mem_w_data  <= w_wdata;
              r_mem_masking <= w_mask;
              r_mem_we_re   <= w_is_store;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (mem_valid) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_load_result <= w_extracted;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_valid) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_load_result <= w_extracted;
          end else if (r_cnt == LP_CNT_LAST) begin
            // Memory never answered: finish with a fault so the core is released.
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done        = r_done;
  assign fault       = r_fault;
  assign misaligned  = r_misaligned;
  assign load_result = r_load_result;
  assign mem_request = r_mem_request;
  assign mem_address = r_mem_address;
  assign mem_w_data  = r_mem_w_data;
  assign mem_masking = r_mem_masking;
  assign mem_we_re   = r_mem_we_re;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-masked memory model plus a result scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic        store_en;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_result;
  logic        misaligned;
  logic        fault;
  logic        mem_request;
  logic [7:0]  mem_address;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_masking;
  logic        mem_we_re;
  logic        mem_valid;
  logic [31:0] mem_r_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .store_en(store_en), .funct3(funct3),
    .addr(addr), .store_data(store_data), .stall(stall), .done(done),
    .load_result(load_result), .misaligned(misaligned), .fault(fault),
    .mem_request(mem_request), .mem_address(mem_address), .mem_w_data(mem_w_data),
    .mem_masking(mem_masking), .mem_we_re(mem_we_re), .mem_valid(mem_valid),
    .mem_r_data(mem_r_data)
  );

  // Memory model: writes on request, answers resp_lat cycles after it (0 = never).
  logic [31:0] tb_mem [0:255];
  logic [7:0]  resp_lat = 8'd1;
  logic [7:0]  m_pend   = 8'd0;
  logic [7:0]  m_addr   = 8'd0;

  assign mem_valid  = (m_pend == 8'd1);
  assign mem_r_data = tb_mem[m_addr];

  always @(posedge clk) begin
    if (mem_request) begin
      m_pend <= resp_lat;
      m_addr <= mem_address;
      if (mem_we_re) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_masking[b]) tb_mem[mem_address][8*b +: 8] <= mem_w_data[8*b +: 8];
        end
      end
    end else if (m_pend != 8'd0) begin
      m_pend <= m_pend - 8'd1;
    end
  end

  typedef struct packed {
    logic [31:0] result;
    logic        flt;
  } exp_t;
  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] res, input logic flt);
    exp_t e;
    e.result = res;
    e.flt    = flt;
    sb_q.push_back(e);
  endtask

  // Presents one op for a single cycle; returns in the cycle after acceptance.
  task automatic accept(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic exp_stall);
    store_en   = st;
    load_en    = !st;
    funct3     = f3;
    addr       = a;
    store_data = d;
    #1;
    chk1({tag, "_accept_stall"}, stall, exp_stall);
    tick();
    store_en   = 1'b0;
    load_en    = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    store_data = '0;
    $display("op %s: st=%0b f3=%03b addr=%h data=%h", tag, st, f3, a, d);
  endtask

  // Waits (bounded) for done, then checks latency from accept and scoreboard result.
  task automatic wait_result(input string tag, input int exp_cycles);
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk32({tag, "_latency"}, 32'(n + 1), 32'(exp_cycles));
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk32({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk32({tag, "_result"}, load_result, e.result);
        chk1({tag, "_fault"}, fault, e.flt);
      end
    end
    $display("done %s: cycles=%0d result=%h fault=%0b", tag, n + 1, load_result, fault);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_stall"}, stall, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk32({tag, "_load_result"}, load_result, 32'h0);
    chk1({tag, "_misaligned"}, misaligned, 1'b0);
    chk1({tag, "_fault"}, fault, 1'b0);
    chk1({tag, "_mem_request"}, mem_request, 1'b0);
    chk32({tag, "_mem_address"}, 32'(mem_address), 32'h0);
    chk32({tag, "_mem_w_data"}, mem_w_data, 32'h0);
    chk32({tag, "_mem_masking"}, 32'(mem_masking), 32'h0);
    chk1({tag, "_mem_we_re"}, mem_we_re, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; store_en = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Preload word 0 through the DUT.
    push_exp(32'h0, 1'b0);
    accept("sw0", 1'b1, 3'b010, 32'h0, 32'h80FF_0011, 1'b1);
    chk1("sw0_req", mem_request, 1'b1);
    chk1("sw0_we", mem_we_re, 1'b1);
    chk32("sw0_mask", 32'(mem_masking), 32'hF);
    chk32("sw0_wdata", mem_w_data, 32'h80FF_0011);
    wait_result("sw0", 3);
    tick();

    // Load extraction from 0x80FF_0011.
    push_exp(32'hFFFF_FF80, 1'b0);
    accept("lb3", 1'b0, 3'b000, 32'h3, 32'h0, 1'b1);
    chk1("lb3_we", mem_we_re, 1'b0);
    chk32("lb3_mask", 32'(mem_masking), 32'hF);
    chk32("lb3_addr", 32'(mem_address), 32'h0);
    wait_result("lb3", 3);
    tick();
    push_exp(32'h0000_0080, 1'b0);
    accept("lbu3", 1'b0, 3'b100, 32'h3, 32'h0, 1'b1);
    wait_result("lbu3", 3);
    tick();
    push_exp(32'hFFFF_80FF, 1'b0);
    accept("lh2", 1'b0, 3'b001, 32'h2, 32'h0, 1'b1);
    wait_result("lh2", 3);
    tick();
    push_exp(32'h0000_0011, 1'b0);
    accept("lhu0", 1'b0, 3'b101, 32'h0, 32'h0, 1'b1);
    wait_result("lhu0", 3);
    tick();
    // Address 0x400 wraps to word 0.
    push_exp(32'h80FF_0011, 1'b0);
    accept("lw_wrap", 1'b0, 3'b010, 32'h0000_0400, 32'h0, 1'b1);
    chk32("lw_wrap_addr", 32'(mem_address), 32'h0);
    wait_result("lw_wrap", 3);
    tick();

    // Sub-word stores into word 1.
    push_exp(32'h0, 1'b0);
    accept("sw4", 1'b1, 3'b010, 32'h4, 32'h0, 1'b1);
    wait_result("sw4", 3);
    tick();
    push_exp(32'h0, 1'b0);
    accept("sb6", 1'b1, 3'b000, 32'h6, 32'h1234_56AB, 1'b1);
    chk1("sb6_req", mem_request, 1'b1);
    chk32("sb6_addr", 32'(mem_address), 32'h1);
    chk32("sb6_mask", 32'(mem_masking), 32'h4);
    chk32("sb6_wdata", mem_w_data, 32'hABAB_ABAB);
    chk1("sb6_we", mem_we_re, 1'b1);
    wait_result("sb6", 3);
    tick();
    push_exp(32'h0, 1'b0);
    accept("sh4", 1'b1, 3'b001, 32'h4, 32'h1234_BEEF, 1'b1);
    chk32("sh4_mask", 32'(mem_masking), 32'h3);
    chk32("sh4_wdata", mem_w_data, 32'hBEEF_BEEF);
    wait_result("sh4", 3);
    tick();
    push_exp(32'h00AB_BEEF, 1'b0);
    accept("lw4", 1'b0, 3'b010, 32'h4, 32'h0, 1'b1);
    wait_result("lw4", 3);
    tick();

    // Misaligned accesses: no memory traffic, one-cycle flag.
    accept("lw2_mis", 1'b0, 3'b010, 32'h2, 32'h0, 1'b0);
    chk1("lw2_mis_flag", misaligned, 1'b1);
    chk1("lw2_mis_req", mem_request, 1'b0);
    chk1("lw2_mis_stall", stall, 1'b0);
    chk1("lw2_mis_done", done, 1'b0);
    tick();
    chk1("lw2_mis_pulse", misaligned, 1'b0);
    chk1("lw2_mis_req2", mem_request, 1'b0);
    accept("sh1_mis", 1'b1, 3'b001, 32'h1, 32'h5555, 1'b0);
    chk1("sh1_mis_flag", misaligned, 1'b1);
    chk1("sh1_mis_req", mem_request, 1'b0);
    chk1("sh1_mis_stall", stall, 1'b0);
    tick();
    chk1("sh1_mis_pulse", misaligned, 1'b0);

    // Illegal funct3.
    push_exp(32'h0, 1'b1);
    accept("ld_ill", 1'b0, 3'b011, 32'h0, 32'h0, 1'b0);
    chk1("ld_ill_req", mem_request, 1'b0);
    wait_result("ld_ill", 1);
    tick();
    push_exp(32'h0, 1'b1);
    accept("st_ill", 1'b1, 3'b100, 32'h0, 32'h0, 1'b0);
    chk1("st_ill_req", mem_request, 1'b0);
    wait_result("st_ill", 1);
    tick();

    // Timeout: memory never answers.
    resp_lat = 8'd0;
    push_exp(32'h0, 1'b1);
    accept("lw_to", 1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
    chk1("lw_to_req", mem_request, 1'b1);
    wait_result("lw_to", 17);
    chk1("lw_to_stall", stall, 1'b0);
    tick();
    resp_lat = 8'd1;

    // Back-to-back: next op presented in the DONE cycle.
    push_exp(32'h0, 1'b0);
    accept("b2b_sw", 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 1'b1);
    wait_result("b2b_sw", 3);
    push_exp(32'hCAFE_F00D, 1'b0);
    accept("b2b_lw", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    chk1("b2b_lw_req", mem_request, 1'b1);
    chk32("b2b_lw_addr", 32'(mem_address), 32'h4);
    chk1("b2b_lw_we", mem_we_re, 1'b0);
    wait_result("b2b_lw", 3);
    tick();

    // Reset in WAIT; memory answers in the cycle after reset.
    resp_lat = 8'd3;
    accept("rst_wait", 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
    tick();
    tick();
    chk1("rst_wait_stall", stall, 1'b1);
    chk1("rst_wait_done", done, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_mid");
    tick();
    chk1("rst_late_done", done, 1'b0);
    chk1("rst_late_stall", stall, 1'b0);
    tick();
    chk1("rst_late_done2", done, 1'b0);
    resp_lat = 8'd1;

    chk32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
